seg7_multi_display: RTL and testbench

Parametrised multi-digit seven-segment display driver. It captures a binary value on a load strobe and converts it to decimal with an iterative shift-and-add-3 (double-dabble) engine, one bit per clock. It then drives NUM_DIGITS active-low digit patterns with optional leading-zero blanking, hexadecimal mode, overflow dashes and blinking. It sits between game/score logic and the board HEX displays, and replaces per-digit single-BCD decoders.

---
 rtl/seg7_multi_display.sv | 185 ++++++++++++++++++
 tb/tb_seg7_multi_display.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_multi_display.sv
// Binary value to NUM_DIGITS active-low 7-segment digits: double-dabble, hex mode, LZ blanking, overflow dashes, blink.
// Decimal load->leds takes WIDTH+1 cycles and hex takes 1 cycle; a load while busy is dropped, nothing is queued.
module seg7_multi_display #(
    parameter int NUM_DIGITS   = 6,
    parameter int WIDTH        = 16,
    parameter int BLINK_PERIOD = 25000000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [WIDTH-1:0]        value,
    input  logic                    hex_mode,
    input  logic                    blank_lz,
    input  logic                    blink_en,
    output logic [NUM_DIGITS*7-1:0] leds,
    output logic                    busy,
    output logic                    done,
    output logic                    overflow
);
    localparam int BW = 4 * NUM_DIGITS;
    localparam int SW = $clog2(WIDTH + 1);
    localparam int CW = $clog2(BLINK_PERIOD + 1);
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    typedef enum logic [1:0] {IDLE, CONVERT, UPDATE} state_t;

    state_t                  state_q, state_d;
    logic [SW-1:0]           step_q, step_d;
    logic [WIDTH-1:0]        shift_q, shift_d;
    logic [BW-1:0]           bcd_q, bcd_d;
    logic                    sticky_q, sticky_d;
    logic                    hex_q, hex_d;
    logic                    blz_q, blz_d;
    logic [NUM_DIGITS*7-1:0] disp_q, disp_d;
    logic                    done_q, done_d;
    logic                    ovf_q, ovf_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    phase_q, phase_d;

    logic                    accept;
    logic [BW-1:0]           bcd_adj;
    logic [BW-1:0]           hexpad;
    logic [BW-1:0]           digits;
    logic                    seen_nz;
    logic [NUM_DIGITS*7-1:0] disp_new;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'h0: seg7 = 7'b1000000;
            4'h1: seg7 = 7'b1111001;
            4'h2: seg7 = 7'b0100100;
            4'h3: seg7 = 7'b0110000;
            4'h4: seg7 = 7'b0011001;
            4'h5: seg7 = 7'b0010010;
            4'h6: seg7 = 7'b0000010;
            4'h7: seg7 = 7'b1111000;
            4'h8: seg7 = 7'b0000000;
            4'h9: seg7 = 7'b0010000;
            4'hA: seg7 = 7'b0001000;
            4'hB: seg7 = 7'b0000011;
            4'hC: seg7 = 7'b1000110;
            4'hD: seg7 = 7'b0100001;
            4'hE: seg7 = 7'b0000110;
            default: seg7 = 7'b0001110;
        endcase
    endfunction

    // Hex UPDATE is not a busy cycle, so a new load may be taken there as well as in IDLE.
    assign busy   = (state_q == CONVERT) || ((state_q == UPDATE) && !hex_q);
    assign accept = load && !busy;

    always_comb begin
        bcd_adj  = '0;
        hexpad   = '0;
        digits   = '0;
        seen_nz  = 1'b0;
        disp_new = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
        end
        for (int b = 0; b < WIDTH && b < BW; b++) begin
            hexpad[b] = shift_q[b];
        end
        digits = hex_q ? hexpad : bcd_q;
        // Walk from the top digit so blanking stops at the first nonzero digit.
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            seen_nz = seen_nz || (digits[4*i +: 4] != 4'd0);
            if (sticky_q && !hex_q) begin
                disp_new[7*i +: 7] = SEG_DASH;
            end else if (blz_q && !seen_nz && (i != 0)) begin
                disp_new[7*i +: 7] = SEG_BLANK;
            end else begin
                disp_new[7*i +: 7] = seg7(digits[4*i +: 4]);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        shift_d  = shift_q;
        bcd_d    = bcd_q;
        sticky_d = sticky_q;
        hex_d    = hex_q;
        blz_d    = blz_q;
        disp_d   = disp_q;
        done_d   = 1'b0;
        ovf_d    = ovf_q;
        cnt_d    = cnt_q;
        phase_d  = phase_q;

        case (state_q)
            CONVERT: begin
                {bcd_d, shift_d} = {bcd_adj, shift_q} << 1;
                if (bcd_adj[BW-1]) begin
                    sticky_d = 1'b1;
                end
                step_d = step_q + 1'b1;
                if (step_q == SW'(WIDTH - 1)) begin
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                disp_d  = disp_new;
                done_d  = 1'b1;
                ovf_d   = sticky_q;
                state_d = IDLE;
            end
            default: ;
        endcase

        if (accept) begin
            shift_d  = value;
            hex_d    = hex_mode;
            blz_d    = blank_lz;
            bcd_d    = '0;
            sticky_d = 1'b0;
            step_d   = '0;
            ovf_d    = 1'b0;
            state_d  = hex_mode ? UPDATE : CONVERT;
        end

        if (cnt_q == CW'(BLINK_PERIOD - 1)) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            step_q   <= '0;
            shift_q  <= '0;
            bcd_q    <= '0;
            sticky_q <= 1'b0;
            hex_q    <= 1'b0;
            blz_q    <= 1'b0;
            disp_q   <= {NUM_DIGITS{SEG_BLANK}};
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            cnt_q    <= '0;
            phase_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            shift_q  <= shift_d;
            bcd_q    <= bcd_d;
            sticky_q <= sticky_d;
            hex_q    <= hex_d;
            blz_q    <= blz_d;
            disp_q   <= disp_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
        end
    end

    assign leds     = (blink_en && !phase_q) ? {NUM_DIGITS{SEG_BLANK}} : disp_q;
    assign done     = done_q;
    assign overflow = ovf_q;
endmodule

// File: tb/tb_seg7_multi_display.sv
// Bench for seg7_multi_display: a 6-digit and a 4-digit instance, vector table plus timing sequences.
module tb_seg7_multi_display;
    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100, S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001, S5 = 7'b0010010, S6 = 7'b0000010, S9 = 7'b0010000;
    localparam logic [6:0] SA = 7'b0001000, SB = 7'b0000011, SE = 7'b0000110, SF = 7'b0001110;
    localparam logic [6:0] DS = 7'b0111111, BL = 7'b1111111;

    logic        clk = 1'b0;
    logic        reset, load_a, load_b, hex_mode, blank_lz, blink_en;
    logic [15:0] value;
    logic [41:0] leds_a;
    logic [27:0] leds_b;
    logic        busy_a, done_a, overflow_a, busy_b, done_b, overflow_b;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          sel;
        logic [41:0] leds;
        logic        ovf;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        bit          sel;
        logic [15:0] val;
        bit          hx;
        bit          bz;
        logic [41:0] leds;
        logic        ovf;
    } vec_t;
    vec_t vecs[11];

    always #5 clk = ~clk;

    seg7_multi_display #(.NUM_DIGITS(6), .WIDTH(16), .BLINK_PERIOD(4)) dut_a (
        .clk(clk), .reset(reset), .load(load_a), .value(value), .hex_mode(hex_mode),
        .blank_lz(blank_lz), .blink_en(blink_en), .leds(leds_a), .busy(busy_a),
        .done(done_a), .overflow(overflow_a)
    );

    seg7_multi_display #(.NUM_DIGITS(4), .WIDTH(16), .BLINK_PERIOD(4)) dut_b (
        .clk(clk), .reset(reset), .load(load_b), .value(value), .hex_mode(hex_mode),
        .blank_lz(blank_lz), .blink_en(blink_en), .leds(leds_b), .busy(busy_b),
        .done(done_b), .overflow(overflow_b)
    );

    function automatic logic [41:0] p6(input logic [6:0] a5, a4, a3, a2, a1, a0);
        return {a5, a4, a3, a2, a1, a0};
    endfunction

    function automatic logic [41:0] p4(input logic [6:0] a3, a2, a1, a0);
        return {14'b0, a3, a2, a1, a0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(input bit sel, input logic [15:0] v, input bit hx, input bit bz);
        value    = v;
        hex_mode = hx;
        blank_lz = bz;
        if (sel) load_b = 1'b1;
        else     load_a = 1'b1;
        tick();
        load_a = 1'b0;
        load_b = 1'b0;
    endtask

    task automatic push(input bit sel, input logic [41:0] l, input logic o);
        exp_t e;
        e.sel  = sel;
        e.leds = l;
        e.ovf  = o;
        sb.push_back(e);
    endtask

    task automatic wait_done(input bit sel, input string name);
        int   n;
        logic d;
        exp_t e;
        n = 0;
        d = sel ? done_b : done_a;
        while (d !== 1'b1 && n < 60) begin
            tick();
            n++;
            d = sel ? done_b : done_a;
        end
        check({name, " done"}, 64'(d), 64'd1);
        if (sb.size() == 0) begin
            check({name, " scoreboard"}, 64'(sb.size()), 64'd1);
        end else begin
            e = sb.pop_front();
            if (e.sel) begin
                check({name, " leds"}, 64'({14'b0, leds_b}), 64'(e.leds));
                check({name, " overflow"}, 64'(overflow_b), 64'(e.ovf));
                check({name, " busy"}, 64'(busy_b), 64'd0);
            end else begin
                check({name, " leds"}, 64'(leds_a), 64'(e.leds));
                check({name, " overflow"}, 64'(overflow_a), 64'(e.ovf));
                check({name, " busy"}, 64'(busy_a), 64'd0);
            end
        end
    endtask

    task automatic no_done_for(input int cycles, input string name);
        int seen;
        seen = 0;
        for (int k = 0; k < cycles; k++) begin
            tick();
            if (done_a === 1'b1) seen++;
        end
        check(name, 64'(seen), 64'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [41:0] p42, pblank;
        logic [19:0] on;
        int          bad, t;

        vecs[0]  = '{0, 16'd1234,  0, 1, p6(BL, BL, S1, S2, S3, S4), 0};
        vecs[1]  = '{0, 16'd0,     0, 1, p6(BL, BL, BL, BL, BL, S0), 0};
        vecs[2]  = '{0, 16'd0,     0, 0, p6(S0, S0, S0, S0, S0, S0), 0};
        vecs[3]  = '{0, 16'hBEEF,  1, 1, p6(BL, BL, SB, SE, SE, SF), 0};
        vecs[4]  = '{1, 16'd12345, 0, 0, p4(DS, DS, DS, DS), 1};
        vecs[5]  = '{1, 16'd9999,  0, 0, p4(S9, S9, S9, S9), 0};
        vecs[6]  = '{0, 16'd65535, 0, 1, p6(BL, S6, S5, S5, S3, S5), 0};
        vecs[7]  = '{0, 16'h00A0,  1, 0, p6(S0, S0, S0, S0, SA, S0), 0};
        vecs[8]  = '{0, 16'd100,   0, 1, p6(BL, BL, BL, S1, S0, S0), 0};
        vecs[9]  = '{1, 16'd10000, 0, 1, p4(DS, DS, DS, DS), 1};
        vecs[10] = '{0, 16'd12345, 1, 1, p6(BL, BL, S3, S0, S3, S9), 0};

        p42    = p6(BL, BL, BL, BL, S4, S2);
        pblank = {6{BL}};

        reset = 1'b1; load_a = 1'b0; load_b = 1'b0; value = '0;
        hex_mode = 1'b0; blank_lz = 1'b0; blink_en = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check("reset leds_a", 64'(leds_a), 64'(pblank));
        check("reset leds_b", 64'({14'b0, leds_b}), 64'(p4(BL, BL, BL, BL)));
        check("reset flags_a", 64'({busy_a, done_a, overflow_a}), 64'd0);
        check("reset flags_b", 64'({busy_b, done_b, overflow_b}), 64'd0);

        // Decimal latency: busy from E0 through E16, done and busy low after E17.
        push(0, p6(BL, BL, S1, S2, S3, S4), 0);
        apply(0, 16'd1234, 0, 1);
        bad = 0;
        for (int k = 0; k <= 16; k++) begin
            if (busy_a !== 1'b1 || done_a !== 1'b0) bad++;
            tick();
        end
        check("latency busy window", 64'(bad), 64'd0);
        check("latency done", 64'({done_a, busy_a}), 64'b10);
        wait_done(0, "latency");
        tick();
        check("done one cycle", 64'(done_a), 64'd0);

        // Hex: busy never rises, done one cycle after the load edge.
        push(0, p6(BL, BL, SB, SE, SE, SF), 0);
        apply(0, 16'hBEEF, 1, 1);
        check("hex E0 busy/done", 64'({busy_a, done_a}), 64'd0);
        tick();
        check("hex E1 busy/done", 64'({busy_a, done_a}), 64'b01);
        wait_done(0, "hex");

        for (int i = 0; i < 11; i++) begin
            push(vecs[i].sel, vecs[i].leds, vecs[i].ovf);
            apply(vecs[i].sel, vecs[i].val, vecs[i].hx, vecs[i].bz);
            wait_done(vecs[i].sel, $sformatf("vec%0d", i));
            if (i == 4) begin
                for (int k = 0; k < 5; k++) tick();
                check("overflow held", 64'(overflow_b), 64'd1);
            end
        end

        // Load while busy is dropped.
        push(0, p6(BL, BL, BL, S5, S0, S0), 0);
        apply(0, 16'd500, 0, 1);
        for (int k = 0; k < 3; k++) tick();
        value = 16'd777;
        load_a = 1'b1;
        tick();
        load_a = 1'b0;
        wait_done(0, "busy ignore");
        no_done_for(30, "busy ignore no second done");

        // Reset mid-conversion aborts and blanks.
        apply(0, 16'd500, 0, 1);
        for (int k = 0; k < 3; k++) tick();
        value = 16'd777;
        load_a = 1'b1;
        tick();
        load_a = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort leds", 64'(leds_a), 64'(pblank));
        check("abort flags", 64'({busy_a, done_a, overflow_a}), 64'd0);
        no_done_for(30, "abort no done");
        check("abort leds stay blank", 64'(leds_a), 64'(pblank));

        // Blink with period 4.
        push(0, p42, 0);
        apply(0, 16'd42, 0, 1);
        wait_done(0, "blink load");
        blink_en = 1'b1;
        tick();
        bad = 0;
        for (int j = 0; j < 20; j++) begin
            on[j] = (leds_a === p42);
            if (leds_a !== p42 && leds_a !== pblank) bad++;
            tick();
        end
        check("blink patterns", 64'(bad), 64'd0);
        t = 0;
        for (int j = 19; j >= 1; j--) begin
            if (on[j] != on[0]) t = j;
        end
        check("blink first toggle in range", 64'(t >= 1 && t <= 4), 64'd1);
        bad = 0;
        if (t >= 1) begin
            for (int j = t; j < 20; j++) begin
                if (on[j] != (on[t] ^ (((j - t) / 4) % 2 == 1))) bad++;
            end
        end
        check("blink period", 64'(bad), 64'd0);
        blink_en = 1'b0;
        bad = 0;
        for (int j = 0; j < 8; j++) begin
            tick();
            if (leds_a !== p42) bad++;
        end
        check("blink off shows value", 64'(bad), 64'd0);
        check("scoreboard drained", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
